// File: rtl/load_align_if.sv
// -----------------------------------------------------------------------------
// load_align_if
//   Bundles the load-request, data-memory read port and response signals of
//   load_align_unit.
//
//   slave  : the load unit itself.
//   master : the environment. It issues requests, serves the memory read port
//            and consumes responses.
//
//   req_valid/req_ready/req_addr/req_funct3 : load request handshake.
//   mem_en/mem_addr/mem_dout                : synchronous data-memory read port.
//   resp_valid/resp_data/resp_err           : one-cycle registered result pulse.
// -----------------------------------------------------------------------------
interface load_align_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_funct3;
    logic                  mem_en;
    logic [ADDR_WIDTH-3:0] mem_addr;
    logic [31:0]           mem_dout;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_addr, req_funct3, mem_dout,
        output req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_addr, req_funct3, mem_dout,
        input  req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
//   Load-path byte alignment. The unit accepts a load (byte address + funct3)
//   and reads the synchronous data memory. It returns the selected
//   byte/half/word, sign- or zero-extended to 32 bits. Half/word loads that
//   cross a word boundary are split into two word reads and then merged. When
//   ALLOW_MISALIGNED=0, such loads are reported as errors instead.
//
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : load_align_if.slave (request, memory read port, response)
// -----------------------------------------------------------------------------
module load_align_unit #(
    parameter int ADDR_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    load_align_if.slave       bus
);
    localparam int DATA_W = 32;
    localparam int WORD_W = ADDR_WIDTH - 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT0, WAIT1} state_t;

    function automatic logic is_valid_f3(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // A load crosses into the next word when its last byte lies beyond byte 3.
    function automatic logic needs_split(input logic [2:0] f3, input logic [1:0] off);
        logic s;
        s = 1'b0;
        case (f3)
            F3_LH, F3_LHU: s = (off == 2'd3);
            F3_LW:         s = (off != 2'd0);
            default:       s = 1'b0;
        endcase
        return s;
    endfunction

    // The requested data is already shifted down to bit 0. Here it is only
    // extended.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] aligned,
                                                      input logic [2:0]        f3);
        logic signed [7:0]        b;
        logic signed [15:0]       h;
        logic signed [DATA_W-1:0] r;
        b = aligned[7:0];
        h = aligned[15:0];
        r = '0;
        case (f3)
            F3_LB:   r = DATA_W'(b);
            F3_LH:   r = DATA_W'(h);
            F3_LW:   r = $signed(aligned);
            F3_LBU:  r = $signed({24'd0, aligned[7:0]});
            F3_LHU:  r = $signed({16'd0, aligned[15:0]});
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t                state;
    logic [2:0]            funct3_p1;
    logic [1:0]            offset_p1;
    logic [WORD_W-1:0]     word_p1;
    logic                  split_p1;
    logic                  err_p1;
    logic [DATA_W-1:0]     lo_p1;

    logic                  req_split;
    logic                  accept;
    logic [2*DATA_W-1:0]   merged;
    logic [DATA_W-1:0]     aligned;
    logic [DATA_W-1:0]     load_result;

    assign req_split = needs_split(bus.req_funct3, bus.req_addr[1:0]);
    assign accept    = (state == IDLE) && bus.req_valid;

    // mem_en is gated with rst_n so that it drops as soon as reset asserts,
    // not only at the next clock edge.
    assign bus.req_ready = rst_n && (state == IDLE);
    assign bus.mem_en    = rst_n && (accept || ((state == WAIT0) && split_p1));
    assign bus.mem_addr  = (state == IDLE) ? bus.req_addr[ADDR_WIDTH-1:2]
                                           : word_p1 + WORD_W'(1);

    // For a split load the two words form one 64-bit window. For a single read
    // the upper half is zero. In both cases the shift brings the addressed
    // byte down to bit 0.
    always_comb begin
        merged      = (state == WAIT1) ? {bus.mem_dout, lo_p1} : {{DATA_W{1'b0}}, bus.mem_dout};
        aligned     = DATA_W'(merged >> {offset_p1, 3'b000});
        load_result = extend_load(aligned, funct3_p1);
    end

    // ---- stage p1: request attributes and low word held across the read ----
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_p1 <= bus.req_funct3;
            offset_p1 <= bus.req_addr[1:0];
            word_p1   <= bus.req_addr[ADDR_WIDTH-1:2];
            split_p1  <= ALLOW_MISALIGNED && req_split;
            err_p1    <= !is_valid_f3(bus.req_funct3) || (!ALLOW_MISALIGNED && req_split);
        end
        if ((state == WAIT0) && split_p1) begin
            lo_p1 <= bus.mem_dout;
        end
    end

    // ---- stage p2: control FSM and registered response ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state <= WAIT0;
                    end
                end
                WAIT0: begin
                    if (split_p1) begin
                        state <= WAIT1;
                    end else begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_data  <= err_p1 ? '0 : load_result;
                        bus.resp_err   <= err_p1;
                        state          <= IDLE;
                    end
                end
                WAIT1: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_data  <= load_result;
                    bus.resp_err   <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// -----------------------------------------------------------------------------
// tb_load_align_unit
//   Directed bench for load_align_unit. It uses one instance with
//   ALLOW_MISALIGNED=1 and one with ALLOW_MISALIGNED=0. Each instance has its
//   own small synchronous memory model.
// -----------------------------------------------------------------------------
module tb_load_align_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   nm_pulses = 0;

    always #5 clk = ~clk;

    load_align_if #(.ADDR_WIDTH(32)) bus ();
    load_align_if #(.ADDR_WIDTH(32)) bus_nm ();

    load_align_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    load_align_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nm.slave)
    );

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        logic [31:0] w;
        case (wa)
            30'h100:      w = 32'h8070F0A5;
            30'h101:      w = 32'h11223344;
            30'h3FFFFFFF: w = 32'hAABBCCDD;
            30'h0:        w = 32'h01020304;
            default:      w = {2'b00, wa} ^ 32'h5A5A5A5A;
        endcase
        return w;
    endfunction

    always @(posedge clk) if (bus.mem_en)    bus.mem_dout    <= mem_word(bus.mem_addr);
    always @(posedge clk) if (bus_nm.mem_en) bus_nm.mem_dout <= mem_word(bus_nm.mem_addr);
    always @(posedge clk) if (bus_nm.mem_en) nm_pulses       <= nm_pulses + 1;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Issues one load on the ALLOW_MISALIGNED=1 instance and checks each cycle.
    // The request is presented in cycle T. The response is checked in cycle T+2,
    // or in cycle T+3 for a split load.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic split, input logic [31:0] exp_data, input logic exp_err);
        logic [29:0] w2;
        w2 = addr[31:2] + 30'd1;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        #1;
        chk1 ({tag, ".ready_T"}, bus.req_ready, 1'b1);
        chk1 ({tag, ".mem_en_T"}, bus.mem_en, 1'b1);
        chk32({tag, ".mem_addr_T"}, {2'b00, bus.mem_addr}, {2'b00, addr[31:2]});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk1({tag, ".ready_T1"}, bus.req_ready, 1'b0);
        chk1({tag, ".resp_valid_T1"}, bus.resp_valid, 1'b0);
        chk1({tag, ".mem_en_T1"}, bus.mem_en, split);
        if (split) begin
            chk32({tag, ".mem_addr_T1"}, {2'b00, bus.mem_addr}, {2'b00, w2});
            @(posedge clk); #1;
            chk1({tag, ".resp_valid_T2"}, bus.resp_valid, 1'b0);
            chk1({tag, ".mem_en_T2"}, bus.mem_en, 1'b0);
        end
        @(posedge clk); #1;
        chk1 ({tag, ".resp_valid"}, bus.resp_valid, 1'b1);
        chk32({tag, ".resp_data"}, bus.resp_data, exp_data);
        chk1 ({tag, ".resp_err"}, bus.resp_err, exp_err);
        chk1 ({tag, ".ready_resp"}, bus.req_ready, 1'b1);
        @(posedge clk); #1;
        chk1 ({tag, ".pulse_end"}, bus.resp_valid, 1'b0);
        chk32({tag, ".data_hold"}, bus.resp_data, exp_data);
    endtask

    initial begin
        int p0;
        rst_n = 1'b0;
        bus.req_valid     = 1'b1;
        bus.req_addr      = 32'h400;
        bus.req_funct3    = 3'b000;
        bus_nm.req_valid  = 1'b0;
        bus_nm.req_addr   = 32'h0;
        bus_nm.req_funct3 = 3'b000;

        // Reset state. req_valid is held high to show that reset gates mem_en.
        repeat (2) @(posedge clk);
        #1;
        chk1 ("rst.ready", bus.req_ready, 1'b0);
        chk1 ("rst.mem_en", bus.mem_en, 1'b0);
        chk1 ("rst.resp_valid", bus.resp_valid, 1'b0);
        chk32("rst.resp_data", bus.resp_data, 32'h0);
        chk1 ("rst.resp_err", bus.resp_err, 1'b0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned loads from the word 0x8070F0A5
        do_load("lb_400",  32'h400, 3'b000, 1'b0, 32'hFFFFFFA5, 1'b0);
        do_load("lbu_403", 32'h403, 3'b100, 1'b0, 32'h00000080, 1'b0);
        do_load("lb_401",  32'h401, 3'b000, 1'b0, 32'hFFFFFFF0, 1'b0);
        do_load("lb_403",  32'h403, 3'b000, 1'b0, 32'hFFFFFF80, 1'b0);
        do_load("lh_402",  32'h402, 3'b001, 1'b0, 32'hFFFF8070, 1'b0);
        do_load("lhu_402", 32'h402, 3'b101, 1'b0, 32'h00008070, 1'b0);
        do_load("lh_401",  32'h401, 3'b001, 1'b0, 32'h000070F0, 1'b0);
        do_load("lhu_400", 32'h400, 3'b101, 1'b0, 32'h0000F0A5, 1'b0);
        do_load("lw_400",  32'h400, 3'b010, 1'b0, 32'h8070F0A5, 1'b0);

        // Loads that cross a word boundary (second word 0x11223344)
        do_load("lw_402_split",  32'h402, 3'b010, 1'b1, 32'h33448070, 1'b0);
        do_load("lw_401_split",  32'h401, 3'b010, 1'b1, 32'h448070F0, 1'b0);
        do_load("lhu_403_split", 32'h403, 3'b101, 1'b1, 32'h00004480, 1'b0);
        do_load("lh_403_split",  32'h403, 3'b001, 1'b1, 32'h00004480, 1'b0);

        // Invalid funct3 codes
        do_load("f3_011", 32'h400, 3'b011, 1'b0, 32'h0, 1'b1);
        do_load("f3_111", 32'h403, 3'b111, 1'b0, 32'h0, 1'b1);

        // Top word 0xAABBCCDD with the address wrapping to word 0 (0x01020304)
        do_load("lw_wrap", 32'hFFFFFFFE, 3'b010, 1'b1, 32'h0304AABB, 1'b0);

        // ALLOW_MISALIGNED=0 instance: aligned word, then a misaligned word
        @(negedge clk);
        bus_nm.req_valid  = 1'b1;
        bus_nm.req_addr   = 32'h400;
        bus_nm.req_funct3 = 3'b010;
        @(posedge clk); #1;
        bus_nm.req_valid = 1'b0;
        @(posedge clk); #1;
        chk1 ("nm_lw_400.resp_valid", bus_nm.resp_valid, 1'b1);
        chk32("nm_lw_400.resp_data", bus_nm.resp_data, 32'h8070F0A5);
        chk1 ("nm_lw_400.resp_err", bus_nm.resp_err, 1'b0);

        @(negedge clk);
        bus_nm.req_valid  = 1'b1;
        bus_nm.req_addr   = 32'h401;
        bus_nm.req_funct3 = 3'b010;
        #1;
        p0 = nm_pulses;
        chk1 ("nm_lw_401.mem_en_T", bus_nm.mem_en, 1'b1);
        chk32("nm_lw_401.mem_addr_T", {2'b00, bus_nm.mem_addr}, 32'h100);
        @(posedge clk); #1;
        bus_nm.req_valid = 1'b0;
        chk1("nm_lw_401.mem_en_T1", bus_nm.mem_en, 1'b0);
        @(posedge clk); #1;
        chk1 ("nm_lw_401.resp_valid", bus_nm.resp_valid, 1'b1);
        chk32("nm_lw_401.resp_data", bus_nm.resp_data, 32'h0);
        chk1 ("nm_lw_401.resp_err", bus_nm.resp_err, 1'b1);
        @(posedge clk); #1;
        chk32("nm_lw_401.pulses", 32'(nm_pulses - p0), 32'd1);
        chk1 ("nm_lw_401.pulse_end", bus_nm.resp_valid, 1'b0);

        // Abort a split load during WAIT1
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h402;
        bus.req_funct3 = 3'b010;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk1("abort.mem_en", bus.mem_en, 1'b0);
        chk1("abort.resp_valid", bus.resp_valid, 1'b0);
        chk1("abort.ready_in_rst", bus.req_ready, 1'b0);
        @(posedge clk); #1;
        chk1("abort.no_resp", bus.resp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("abort.ready_after", bus.req_ready, 1'b1);
        do_load("lb_after_abort", 32'h400, 3'b000, 1'b0, 32'hFFFFFFA5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
Load-path counterpart of the store byte-mask logic: accepts a load request (byte address + funct3), reads the synchronous data memory, and returns the selected byte/half/word, sign- or zero-extended to 32 bits. It sits between the memory stage and the data memory read port. Word-boundary-crossing LH/LHU/LW loads are split into two sequential word reads and merged.

Parameters:
ADDR_WIDTH, 32, byte-address width; memory word address is ADDR_WIDTH-2 bits.
ALLOW_MISALIGNED, 1, 1 = split boundary-crossing loads; 0 = flag them as errors.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  load request present.
req_ready  out  1  unit can accept a request (high only in IDLE).
req_addr  in  ADDR_WIDTH  byte address.
req_funct3  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101.
mem_en  out  1  read strobe to data memory (combinational).
mem_addr  out  ADDR_WIDTH-2  word address (combinational).
mem_dout  in  32  read data, valid the cycle after mem_en.
resp_valid  out  1  one-cycle result pulse (registered).
resp_data  out  32  extended load result (registered).
resp_err  out  1  invalid funct3 or disallowed misalignment (registered).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; resp_valid=0, resp_data=0, resp_err=0; mem_en=0; req_ready=0 while rst_n low.
- States: IDLE, WAIT0, WAIT1.
- IDLE: req_ready=1. Accept on req_valid: mem_en=1, mem_addr=req_addr[ADDR_WIDTH-1:2] in the same cycle; latch funct3, offset=req_addr[1:0], word address; -> WAIT0.
- Split condition: (LH/LHU and offset==3) or (LW and offset!=0), only when ALLOW_MISALIGNED=1.
- WAIT0, no split: extract from mem_dout; register resp_valid=1 and resp_data/resp_err; -> IDLE. Latency: accept at T, resp_valid at T+2.
- WAIT0, split: latch mem_dout as lo; mem_en=1, mem_addr=latched word+1 (wraps modulo 2^(ADDR_WIDTH-2)); -> WAIT1.
- WAIT1: hi=mem_dout; merge {hi,lo} >> (offset*8), keep low 32; extend; resp_valid=1; -> IDLE. Response at T+3.
- Extraction: byte = word >> (offset*8); half = word >> (offset*8) for offset 0-2. LB/LH sign-extend; LBU/LHU zero-extend; LW unextended.
- Invalid funct3 (011, 110, 111): a single read is still issued; response at T+2 with resp_data=0, resp_err=1.
- ALLOW_MISALIGNED=0 and split condition true: a single read; resp_data=0, resp_err=1 at T+2.
- resp_valid is high exactly one cycle and needs no ready; the consumer must take it. resp_data/resp_err hold until the next response.
- req_ready is low in WAIT0/WAIT1, including the cycle in which resp_valid is registered. Back-to-back throughput is one load per 2 cycles (aligned) or 3 cycles (split).
- Reset mid-operation: abort immediately to IDLE. No resp_valid for the aborted load; mem_en drops asynchronously.

Test Plan:
- Memory word 0x100=0x8070F0A5. LB at 0x400 -> resp_data=0xFFFFFFA5, resp_valid at T+2, resp_err=0. LBU at 0x403 -> 0x00000080.
- Same word: LH at 0x402 -> 0xFFFF8070; LHU at 0x402 -> 0x00008070; LW at 0x400 -> 0x8070F0A5.
- Word 0x101=0x11223344. LW at 0x402 -> mem_addr 0x100 at T, then 0x101 at T+1; resp_data=0x33448070 at T+3. LHU at 0x403 -> 0x00004480.
- funct3=011 at 0x400 -> resp_err=1, resp_data=0 at T+2. With ALLOW_MISALIGNED=0, LW at 0x401 -> resp_err=1, one mem_en pulse only.
- Word address 0x3FFFFFFF (byte 0xFFFFFFFE), LW split -> second mem_addr=0x00000000 (wrap).
- Drop rst_n during WAIT1 -> resp_valid stays 0, mem_en=0. After release, req_ready=1 and the next LB completes normally.
